// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Shared definitions for the Pong video path and game logic:
//   - default 640x480@60 VGA timing and the derived line/frame totals
//   - RRRGGGBB colour constants used by the renderer
//   - game_sm state encodings, so renderer/debug logic decode states the same way
//   - the per-frame geometry snapshot and stage-1 hit-flag structs
// -----------------------------------------------------------------------------
package pong_pkg;

  // Default VGA timing (pixels / lines)
  localparam int PIX_DIV_DEFAULT  = 2;
  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int H_FP_DEFAULT     = 16;
  localparam int H_SYNC_DEFAULT   = 96;
  localparam int H_BP_DEFAULT     = 48;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int V_FP_DEFAULT     = 10;
  localparam int V_SYNC_DEFAULT   = 2;
  localparam int V_BP_DEFAULT     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEFAULT + H_FP_DEFAULT + H_SYNC_DEFAULT + H_BP_DEFAULT;
  localparam int V_TOTAL = V_ACTIVE_DEFAULT + V_FP_DEFAULT + V_SYNC_DEFAULT + V_BP_DEFAULT;

  // RRRGGGBB colours
  localparam logic [7:0] COL_BALL    = 8'hFF;
  localparam logic [7:0] COL_PADDLE  = 8'h1C;
  localparam logic [7:0] COL_WALL    = 8'hB6;
  localparam logic [7:0] COL_CENTRE  = 8'h92;
  localparam logic [7:0] COL_BG      = 8'h00;
  localparam logic [7:0] COL_BG_OVER = 8'h20;
  localparam logic [7:0] COL_BLANK   = 8'h00;

  // game_sm state encodings
  typedef enum logic [2:0] {
    GS_RESET     = 3'd0,
    GS_SERVE     = 3'd1,
    GS_PLAY      = 3'd2,
    GS_POINT     = 3'd3,
    GS_GAME_OVER = 3'd4
  } game_state_e;

  // Geometry captured once per frame; drawing only ever looks at this copy.
  typedef struct packed {
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] pad_left;
    logic [9:0] pad_right;
    logic [9:0] pad_w;
    logic [9:0] pad_h;
    logic [9:0] pad_off;
    logic [9:0] ball_size;
    logic [9:0] bord_top;
    logic [9:0] bord_bot;
    logic [9:0] bord_left;
    logic [9:0] bord_right;
    logic       game_over;
  } geom_t;

  // Stage-1 result: which objects cover the current pixel.
  typedef struct packed {
    logic active;
    logic ball;
    logic paddle;
    logic wall;
    logic centre;
    logic bg_over;
  } hit_t;

  // Zero-extend a 10-bit coordinate so sums of up to three terms cannot wrap.
  function automatic logic [11:0] widen(input logic [9:0] v);
    return {2'b00, v};
  endfunction

endpackage

// File: rtl/pong_renderer_vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//   Pixel-rate divider, horizontal/vertical counters, raw (undelayed) sync and
//   the once-per-frame tick that starts vertical blanking.
//
//   clk, reset   : system clock, synchronous active-high reset
//   pix_en       : one-clk strobe per pixel; every counter advances on it
//   h_cnt, v_cnt : current pixel column / line
//   active       : counters are inside the visible area
//   hsync_raw    : active-low hsync aligned with the counters
//   vsync_raw    : active-low vsync aligned with the counters
//   frame_tick   : one-clk pulse when (h_cnt, v_cnt) = (0, V_ACTIVE) on pix_en
// -----------------------------------------------------------------------------
module vga_timing
  import pong_pkg::*;
#(
  parameter int PIX_DIV  = PIX_DIV_DEFAULT,
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int H_FP     = H_FP_DEFAULT,
  parameter int H_SYNC   = H_SYNC_DEFAULT,
  parameter int H_BP     = H_BP_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int V_FP     = V_FP_DEFAULT,
  parameter int V_SYNC   = V_SYNC_DEFAULT,
  parameter int V_BP     = V_BP_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       frame_tick
);

  localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [1:0] PIX_LAST = 2'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(LINE_LEN - 1);
  localparam logic [9:0] V_LAST   = 10'(FRAME_LINES - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [1:0] pix_div_cnt_q, pix_div_cnt_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pix_en        = (pix_div_cnt_q == PIX_LAST);
    pix_div_cnt_d = pix_en ? 2'd0 : pix_div_cnt_q + 2'd1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_div_cnt_q <= 2'd0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
    end else begin
      pix_div_cnt_q <= pix_div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
    end
  end

  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;
  assign active    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hsync_raw = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
  assign vsync_raw = !((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END));
  // Qualified by pix_en so the pulse lasts one clk, not PIX_DIV clks.
  assign frame_tick = pix_en && (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS);

endmodule

// File: rtl/pong_renderer.sv
// -----------------------------------------------------------------------------
// pong_renderer
//   Draws the Pong play field on a VGA output. Geometry from game_sm is
//   snapshotted at frame_tick (start of vertical blanking) so a whole frame is
//   drawn from one game state. A two-stage pipeline (hit flags, then colour)
//   follows the counters; hsync/vsync are delayed to stay aligned with rgb.
//
//   clk, reset              : system clock, synchronous active-high reset
//   ball_pos_x/ball_pos_y   : ball top-left corner
//   player_left/right_pos   : paddle top edges
//   paddle_width/height/offset, ball_size : object sizes
//   border_top/bottom/left/right          : play-field bounds
//   game_over_signal        : selects the game-over background colour
//   hsync, vsync            : active-low sync, aligned with rgb
//   rgb                     : RRRGGGBB pixel, 0 outside the visible area
//   frame_tick              : one-clk pulse per frame, drives game_sm frame_clk
// -----------------------------------------------------------------------------
module pong_renderer
  import pong_pkg::*;
#(
  parameter int PIX_DIV  = PIX_DIV_DEFAULT,
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int H_FP     = H_FP_DEFAULT,
  parameter int H_SYNC   = H_SYNC_DEFAULT,
  parameter int H_BP     = H_BP_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int V_FP     = V_FP_DEFAULT,
  parameter int V_SYNC   = V_SYNC_DEFAULT,
  parameter int V_BP     = V_BP_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ball_pos_x,
  input  logic [9:0] ball_pos_y,
  input  logic [9:0] player_left_pos,
  input  logic [9:0] player_right_pos,
  input  logic [9:0] paddle_width,
  input  logic [9:0] paddle_height,
  input  logic [9:0] paddle_offset,
  input  logic [9:0] ball_size,
  input  logic [9:0] border_top,
  input  logic [9:0] border_bottom,
  input  logic [9:0] border_left,
  input  logic [9:0] border_right,
  input  logic       game_over_signal,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_tick
);

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active;
  logic       hsync_raw;
  logic       vsync_raw;

  vga_timing #(
    .PIX_DIV  (PIX_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .frame_tick (frame_tick)
  );

  // ---------------------------------------------------------------------------
  // Geometry snapshot
  // ---------------------------------------------------------------------------
  geom_t geom_in;
  geom_t geom_q, geom_d;

  always_comb begin
    geom_in = '{
      ball_x:     ball_pos_x,
      ball_y:     ball_pos_y,
      pad_left:   player_left_pos,
      pad_right:  player_right_pos,
      pad_w:      paddle_width,
      pad_h:      paddle_height,
      pad_off:    paddle_offset,
      ball_size:  ball_size,
      bord_top:   border_top,
      bord_bot:   border_bottom,
      bord_left:  border_left,
      bord_right: border_right,
      game_over:  game_over_signal
    };
    geom_d = frame_tick ? geom_in : geom_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: hit flags. Bounds are compared in 12 bits so a+b (+c) never wraps,
  // and "x <= hi-1" is written as "x < hi" so a zero size gives an empty range
  // instead of a huge one.
  // ---------------------------------------------------------------------------
  logic [11:0] x, y;
  logic [11:0] bx, by, bs, pl, pr, pw, ph, po, bt, bb, bl, br;
  logic [11:0] centre_x;
  hit_t        hit_now;
  hit_t        hit_q, hit_d;
  logic        hsync_s1_q, hsync_s1_d;
  logic        vsync_s1_q, vsync_s1_d;

  always_comb begin
    x  = widen(h_cnt);
    y  = widen(v_cnt);
    bx = widen(geom_q.ball_x);
    by = widen(geom_q.ball_y);
    bs = widen(geom_q.ball_size);
    pl = widen(geom_q.pad_left);
    pr = widen(geom_q.pad_right);
    pw = widen(geom_q.pad_w);
    ph = widen(geom_q.pad_h);
    po = widen(geom_q.pad_off);
    bt = widen(geom_q.bord_top);
    bb = widen(geom_q.bord_bot);
    bl = widen(geom_q.bord_left);
    br = widen(geom_q.bord_right);
    centre_x = (bl + br) >> 1;

    hit_now         = '0;
    hit_now.active  = active;
    hit_now.bg_over = geom_q.game_over;
    hit_now.ball    = (x >= bx) && (x < bx + bs) && (y >= by) && (y < by + bs);
    // Left paddle spans (bl+off, bl+off+w]; right paddle [br-off-w, br-off),
    // rearranged so nothing is subtracted.
    hit_now.paddle  = ((x > bl + po) && (x <= bl + po + pw) &&
                       (y >= pl) && (y < pl + ph)) ||
                      ((x + po + pw >= br) && (x + po < br) &&
                       (y >= pr) && (y < pr + ph));
    // Top wall sits on the line just above bt.
    hit_now.wall    = ((y + 12'd1 == bt) || (y == bb)) && (x >= bl) && (x < br);
    // Dashed: 8 lines on, 8 lines off.
    hit_now.centre  = (x + 12'd1 == centre_x) && (y >= bt) && (y < bb) && !y[3];

    hit_d      = pix_en ? hit_now   : hit_q;
    hsync_s1_d = pix_en ? hsync_raw : hsync_s1_q;
    vsync_s1_d = pix_en ? vsync_raw : vsync_s1_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour priority, plus the matching second sync delay.
  // ---------------------------------------------------------------------------
  logic [7:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      hsync_d = hsync_s1_q;
      vsync_d = vsync_s1_q;
      if (!hit_q.active)      rgb_d = COL_BLANK;
      else if (hit_q.ball)    rgb_d = COL_BALL;
      else if (hit_q.paddle)  rgb_d = COL_PADDLE;
      else if (hit_q.wall)    rgb_d = COL_WALL;
      else if (hit_q.centre)  rgb_d = COL_CENTRE;
      else if (hit_q.bg_over) rgb_d = COL_BG_OVER;
      else                    rgb_d = COL_BG;
    end
  end

  // NOTE: the snapshot bank is a handful of flops, not a RAM, so it is reset
  // along with everything else; the first frame after reset draws from zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      geom_q     <= '0;
      hit_q      <= '0;
      hsync_s1_q <= 1'b1;
      vsync_s1_q <= 1'b1;
      rgb_q      <= COL_BLANK;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      geom_q     <= geom_d;
      hit_q      <= hit_d;
      hsync_s1_q <= hsync_s1_d;
      vsync_s1_q <= vsync_s1_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign rgb   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_pong_renderer.sv
// -----------------------------------------------------------------------------
// tb_pong_renderer
//   Directed bench for pong_renderer, run with a reduced video timing
//   (40x32 visible, 56x40 total, PIX_DIV=2) so several frames fit in a short
//   run. A monitor keeps its own pixel position from the clock count since
//   reset release, captures each visible pixel into a per-frame buffer and
//   checks sync levels and blanking colour at every pixel.
//
//   Pixel p after release (counting the first non-reset edge as edge 0) is
//   held by the counters from edge p*D-1; stage 1 loads it at edge p*D+D-1 and
//   stage 2 at edge p*D+2D-1, where it is sampled.
// -----------------------------------------------------------------------------
module tb_pong_renderer;

  localparam int D        = 2;
  localparam int H_ACTIVE = 40;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 6;
  localparam int H_BP     = 6;
  localparam int V_ACTIVE = 32;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 4;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 56
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 40
  localparam int FRAME_PIX  = H_TOT * V_TOT;                   // 2240
  localparam int FRAME_CLKS = FRAME_PIX * D;                   // 4480
  localparam int HS_FALL    = (H_ACTIVE + H_FP) * D + 2 * D - 1;           // 91
  localparam int VS_FALL    = (V_ACTIVE + V_FP) * H_TOT * D + 2 * D - 1;   // 3811
  localparam int TICK_EDGE  = V_ACTIVE * H_TOT * D + D - 2;                // 3584

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] ball_pos_x, ball_pos_y, player_left_pos, player_right_pos;
  logic [9:0] paddle_width, paddle_height, paddle_offset, ball_size;
  logic [9:0] border_top, border_bottom, border_left, border_right;
  logic       game_over_signal;
  logic       hsync, vsync, frame_tick;
  logic [7:0] rgb;

  pong_renderer #(
    .PIX_DIV (D), .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ball_pos_x       (ball_pos_x),
    .ball_pos_y       (ball_pos_y),
    .player_left_pos  (player_left_pos),
    .player_right_pos (player_right_pos),
    .paddle_width     (paddle_width),
    .paddle_height    (paddle_height),
    .paddle_offset    (paddle_offset),
    .ball_size        (ball_size),
    .border_top       (border_top),
    .border_bottom    (border_bottom),
    .border_left      (border_left),
    .border_right     (border_right),
    .game_over_signal (game_over_signal),
    .hsync            (hsync),
    .vsync            (vsync),
    .rgb              (rgb),
    .frame_tick       (frame_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int   edge_n    = -1;
  bit   store_en  = 1'b0;
  int   tick_cnt  = 0;
  int   bad_tick  = 0;
  int   hs_bad    = 0;
  int   vs_bad    = 0;
  int   blank_bad = 0;
  logic prev_tick = 1'b0;
  logic [7:0] fb [0:3][0:V_ACTIVE-1][0:H_ACTIVE-1];

  always @(posedge clk) begin
    if (reset === 1'b1) edge_n = -1;
    else                edge_n = edge_n + 1;
  end

  always @(negedge clk) begin
    if (frame_tick === 1'b1) begin
      tick_cnt++;
      if (edge_n < 0 || ((edge_n - TICK_EDGE) % FRAME_CLKS) != 0) bad_tick++;
      if (prev_tick === 1'b1) bad_tick++;
    end
    prev_tick = frame_tick;
    if (edge_n >= 2 * D - 1 && ((edge_n - 2 * D + 1) % D) == 0) begin
      int p, f, r, px, py;
      p  = (edge_n - 2 * D + 1) / D;
      f  = p / FRAME_PIX;
      r  = p % FRAME_PIX;
      py = r / H_TOT;
      px = r % H_TOT;
      if (hsync !== !(px >= H_ACTIVE + H_FP && px < H_ACTIVE + H_FP + H_SYNC)) hs_bad++;
      if (vsync !== !(py >= V_ACTIVE + V_FP && py < V_ACTIVE + V_FP + V_SYNC)) vs_bad++;
      if (px < H_ACTIVE && py < V_ACTIVE) begin
        if (store_en && f < 4) fb[f][py][px] = rgb;
      end else if (rgb !== 8'h00) begin
        blank_bad++;
      end
    end
  end

  function automatic logic [7:0] pix(input int f, input int px, input int py);
    return fb[f][py][px];
  endfunction

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  // Wait (bounded) until hsync is low; reports the edge it was first seen at.
  task automatic wait_hsync_low(output int at_edge);
    int guard = 0;
    while (hsync !== 1'b0 && guard < 2000) begin @(negedge clk); guard++; end
    at_edge = edge_n;
  endtask

  task automatic wait_tick(output int at_edge);
    int guard = 0;
    while (frame_tick !== 1'b1 && guard < 2 * FRAME_CLKS) begin @(negedge clk); guard++; end
    at_edge = edge_n;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int e, lo;
    reset            = 1'b1;
    border_left      = 10'd2;
    border_right     = 10'd38;
    border_top       = 10'd2;
    border_bottom    = 10'd30;
    ball_size        = 10'd4;
    ball_pos_x       = 10'd20;
    ball_pos_y       = 10'd10;
    paddle_offset    = 10'd2;
    paddle_width     = 10'd3;
    paddle_height    = 10'd10;
    player_left_pos  = 10'd20;
    player_right_pos = 10'd20;
    game_over_signal = 1'b0;
    store_en         = 1'b1;

    // Reset values while reset is held
    @(negedge clk);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'h00);
    check("rst_tick", 32'(frame_tick), 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;

    // Horizontal sync timing
    wait_hsync_low(e);
    check("hs_first_fall", 32'(e), 32'(HS_FALL));
    lo = 0;
    while (hsync === 1'b0 && lo < 2000) begin lo++; @(negedge clk); end
    check("hs_low_clks", 32'(lo), 32'(H_SYNC * D));
    wait_hsync_low(e);
    check("hs_line_period", 32'(e - HS_FALL), 32'(H_TOT * D));

    // First frame tick and vertical sync
    wait_tick(e);
    check("tick_first", 32'(e), 32'(TICK_EDGE));
    @(negedge clk);
    check("tick_width", 32'(frame_tick), 32'd0);
    while (vsync !== 1'b0 && edge_n < VS_FALL + 10) @(negedge clk);
    check("vs_first_fall", 32'(edge_n), 32'(VS_FALL));

    // Mid-frame change in frame 1 (line 5): only frame 2 may see it
    wait_edge((FRAME_PIX + 5 * H_TOT) * D);
    ball_pos_x = 10'd12;

    // Frame 2 (line 20): ball over left paddle, game over, for frame 3
    wait_edge((2 * FRAME_PIX + 20 * H_TOT) * D + 3);
    ball_pos_x       = 10'd6;
    ball_pos_y       = 10'd12;
    player_left_pos  = 10'd8;
    game_over_signal = 1'b1;

    wait_edge(4 * FRAME_CLKS + 100);

    // Frame 0 draws from the all-zero snapshot
    check("f0_ball_pos", 32'(pix(0, 20, 10)), 32'h00);
    check("f0_wall_pos", 32'(pix(0, 10, 1)), 32'h00);
    // Frame 1: ball at (20,10)
    check("f1_ball_tl", 32'(pix(1, 20, 10)), 32'hFF);
    check("f1_ball_br", 32'(pix(1, 23, 13)), 32'hFF);
    check("f1_ball_xout", 32'(pix(1, 24, 10)), 32'h00);
    check("f1_ball_yout", 32'(pix(1, 20, 14)), 32'h00);
    check("f1_centre_on", 32'(pix(1, 19, 4)), 32'h92);
    check("f1_centre_gap", 32'(pix(1, 19, 8)), 32'h00);
    check("f1_wall_top", 32'(pix(1, 10, 1)), 32'hB6);
    check("f1_wall_bot_end", 32'(pix(1, 37, 30)), 32'hB6);
    check("f1_wall_bot_past", 32'(pix(1, 38, 30)), 32'h00);
    check("f1_lpad_first", 32'(pix(1, 5, 20)), 32'h1C);
    check("f1_lpad_last", 32'(pix(1, 7, 29)), 32'h1C);
    check("f1_lpad_left_out", 32'(pix(1, 4, 20)), 32'h00);
    check("f1_lpad_right_out", 32'(pix(1, 8, 20)), 32'h00);
    check("f1_rpad_first", 32'(pix(1, 33, 20)), 32'h1C);
    check("f1_rpad_last", 32'(pix(1, 35, 29)), 32'h1C);
    check("f1_rpad_right_out", 32'(pix(1, 36, 20)), 32'h00);
    check("f1_rpad_left_out", 32'(pix(1, 32, 20)), 32'h00);
    check("f1_pad_below_is_wall", 32'(pix(1, 5, 30)), 32'hB6);
    // Frame 2: new ball x from the snapshot
    check("f2_ball_tl", 32'(pix(2, 12, 10)), 32'hFF);
    check("f2_ball_br", 32'(pix(2, 15, 13)), 32'hFF);
    check("f2_old_ball_gone", 32'(pix(2, 20, 10)), 32'h00);
    check("f2_ball_left_out", 32'(pix(2, 11, 10)), 32'h00);
    // Frame 3: ball over left paddle, game-over background
    check("f3_overlap_a", 32'(pix(3, 6, 12)), 32'hFF);
    check("f3_overlap_b", 32'(pix(3, 7, 15)), 32'hFF);
    check("f3_pad_only_a", 32'(pix(3, 5, 12)), 32'h1C);
    check("f3_pad_only_b", 32'(pix(3, 5, 8)), 32'h1C);
    check("f3_pad_only_c", 32'(pix(3, 7, 17)), 32'h1C);
    check("f3_ball_only", 32'(pix(3, 9, 15)), 32'hFF);
    check("f3_bg_over_a", 32'(pix(3, 10, 12)), 32'h20);
    check("f3_bg_over_b", 32'(pix(3, 5, 18)), 32'h20);
    check("f3_rpad", 32'(pix(3, 33, 20)), 32'h1C);
    check("f3_wall", 32'(pix(3, 10, 1)), 32'hB6);
    check("f3_centre", 32'(pix(3, 19, 4)), 32'h92);
    check("ticks_before_reset", 32'(tick_cnt), 32'd4);

    // Reset in the middle of frame 4 (line 20)
    wait_edge((4 * FRAME_PIX + 20 * H_TOT) * D);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_hsync", 32'(hsync), 32'd1);
    check("mid_rst_vsync", 32'(vsync), 32'd1);
    check("mid_rst_rgb", 32'(rgb), 32'h00);
    check("mid_rst_tick", 32'(frame_tick), 32'd0);
    store_en = 1'b0;
    tick_cnt = 0;
    reset    = 1'b0;
    wait_hsync_low(e);
    check("mid_rst_hs_fall", 32'(e), 32'(HS_FALL));
    wait_tick(e);
    check("mid_rst_tick_edge", 32'(e), 32'(TICK_EDGE));
    @(negedge clk);
    check("ticks_after_reset", 32'(tick_cnt), 32'd1);

    // Whole-run monitor results
    check("tick_alignment", 32'(bad_tick), 32'd0);
    check("hsync_per_pixel", 32'(hs_bad), 32'd0);
    check("vsync_per_pixel", 32'(vs_bad), 32'd0);
    check("blank_rgb_zero", 32'(blank_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
